// File: rtl/spike_frame_packer.sv
// Spike frame packer: assembles WIDTH-bit spike words into one N_SPIKES-bit frame with a
// valid/ready frame handshake. Define SPIKE_FRAME_PACKER_POPCNT_EN to add spike_count_o.
module spike_frame_packer #(
  parameter int WIDTH    = 32,
  parameter int N_SPIKES = 784,
  localparam int N_WORDS = (N_SPIKES + WIDTH - 1) / WIDTH,
  localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic [WIDTH-1:0]    word_i,
  input  logic                word_valid_i,
  output logic                word_ready_o,
  output logic [N_SPIKES-1:0] frame_o,
  output logic                frame_valid_o,
  input  logic                frame_ready_i,
  output logic [IDX_W-1:0]    word_idx_o
`ifdef SPIKE_FRAME_PACKER_POPCNT_EN
  ,
  output logic [$clog2(N_SPIKES+1)-1:0] spike_count_o
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [N_SPIKES-1:0]   frame_q, frame_d;
  logic                  wordAccept;
  logic                  frameTake;

  // Ready/valid come straight from the state register, so frame_ready_i never reaches word_ready_o.
  always_comb begin
    wordAccept = (state_q == FILL) && word_valid_i;
    frameTake  = (state_q == FULL) && frame_ready_i;
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    frame_d       = frame_q;
    word_ready_o  = (state_q == FILL);
    frame_valid_o = (state_q == FULL);

    if (clear_i) begin
      state_d = FILL;
      idx_d   = '0;
      frame_d = '0;
    end else if (wordAccept) begin
      // Bits past N_SPIKES in the last word simply have no destination.
      for (int b = 0; b < N_SPIKES; b++) begin
        if ((b / WIDTH) == int'(idx_q)) begin
          frame_d[b] = word_i[b % WIDTH];
        end
      end
      if (idx_q == LAST_IDX) begin
        state_d = FULL;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else if (frameTake) begin
      state_d = FILL;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FILL;
      idx_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
    end
  end

  assign frame_o    = frame_q;
  assign word_idx_o = idx_q;

`ifdef SPIKE_FRAME_PACKER_POPCNT_EN
  localparam int CNT_W     = $clog2(N_SPIKES + 1);
  localparam int LAST_BITS = N_SPIKES - (N_WORDS - 1) * WIDTH;

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] wordOnes;

  // Only bits that actually land in the frame contribute to the count.
  always_comb begin
    wordOnes = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if ((idx_q != LAST_IDX) || (k < LAST_BITS)) begin
        wordOnes = wordOnes + CNT_W'(word_i[k]);
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (clear_i || frameTake) begin
      count_d = '0;
    end else if (wordAccept) begin
      count_d = count_q + wordOnes;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign spike_count_o = count_q;
`endif

endmodule

// File: tb/tb_spike_frame_packer.sv
// Self-checking bench for spike_frame_packer: directed scenarios plus 100 random frames,
// all compared cycle by cycle against a word-buffer reference model.
module tb_spike_frame_packer;

  localparam int WIDTH     = 32;
  localparam int N_SPIKES  = 784;
  localparam int N_WORDS   = 25;
  localparam int LAST_BITS = N_SPIKES - (N_WORDS - 1) * WIDTH;
  localparam int IDX_W     = 5;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                clear_i;
  logic [WIDTH-1:0]    word_i;
  logic                word_valid_i;
  logic                word_ready_o;
  logic [N_SPIKES-1:0] frame_o;
  logic                frame_valid_o;
  logic                frame_ready_i;
  logic [IDX_W-1:0]    word_idx_o;
`ifdef SPIKE_FRAME_PACKER_POPCNT_EN
  logic [$clog2(N_SPIKES+1)-1:0] spike_count_o;
`endif

  spike_frame_packer #(.WIDTH(WIDTH), .N_SPIKES(N_SPIKES)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .word_i        (word_i),
    .word_valid_i  (word_valid_i),
    .word_ready_o  (word_ready_o),
    .frame_o       (frame_o),
    .frame_valid_o (frame_valid_o),
    .frame_ready_i (frame_ready_i),
    .word_idx_o    (word_idx_o)
`ifdef SPIKE_FRAME_PACKER_POPCNT_EN
    ,
    .spike_count_o (spike_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Reference model: the frame is a flat buffer of whole words, truncated to N_SPIKES on compare.
  logic [N_WORDS*WIDTH-1:0] refBuf;
  int                       refIdx;
  bit                       refFull;
  int                       refCount;

  int vectorCount = 0;
  int miscompareCount = 0;

  task automatic checkOutput(input string tag, input logic [1023:0] observed,
                             input logic [1023:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    refBuf   = '0;
    refIdx   = 0;
    refFull  = 1'b0;
    refCount = 0;
  endtask

  // Compare every visible output against the model's current picture of the block.
  task automatic checkAll();
    checkOutput("word_ready", 1024'(word_ready_o), 1024'(!refFull));
    checkOutput("frame_valid", 1024'(frame_valid_o), 1024'(refFull));
    if (!refFull) checkOutput("word_idx", 1024'(word_idx_o), 1024'(refIdx));
    checkOutput("frame", 1024'(frame_o), 1024'(refBuf[N_SPIKES-1:0]));
`ifdef SPIKE_FRAME_PACKER_POPCNT_EN
    checkOutput("spike_count", 1024'(spike_count_o), 1024'(refCount));
    if (refFull) checkOutput("count_vs_frame", 1024'(spike_count_o), 1024'($countones(frame_o)));
`endif
  endtask

  // Drive one cycle of inputs, advance the model by the same cycle, then check after the edge.
  task automatic applyStimulus(input bit valid, input logic [WIDTH-1:0] word,
                               input bit fready, input bit clr);
    logic [WIDTH-1:0] masked;
    word_valid_i  = valid;
    word_i        = word;
    frame_ready_i = fready;
    clear_i       = clr;
    if (clr) begin
      modelReset();
    end else if (!refFull && valid) begin
      refBuf[refIdx*WIDTH +: WIDTH] = word;
      masked = (refIdx == N_WORDS - 1) ? (word & ((32'h1 << LAST_BITS) - 1)) : word;
      refCount += $countones(masked);
      if (refIdx == N_WORDS - 1) refFull = 1'b1;
      else refIdx++;
    end else if (refFull && fready) begin
      refFull  = 1'b0;
      refIdx   = 0;
      refCount = 0;
    end
    @(posedge clk_i);
    #1;
    checkAll();
  endtask

  initial begin
    logic [15:0] topBits;
    int prevCount;
    int framesDone;
    int cycles;
    bit v, c, fr;

    rst_ni = 1'b0;
    clear_i = 1'b0;
    word_i = '0;
    word_valid_i = 1'b0;
    frame_ready_i = 1'b0;
    modelReset();
    repeat (2) @(posedge clk_i);
    #1;
    checkAll();
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    checkAll();
    checkOutput("reset_ready", 1024'(word_ready_o), 1024'(1));

    // Words 0..24 carry their own index; frame held with no consumer.
    for (int j = 0; j < N_WORDS; j++) applyStimulus(1'b1, WIDTH'(j), 1'b0, 1'b0);
    checkOutput("ramp_valid", 1024'(frame_valid_o), 1024'(1));
    checkOutput("ramp_ready", 1024'(word_ready_o), 1024'(0));
    topBits = frame_o[783:768];
    checkOutput("ramp_top", 1024'(topBits), 1024'(16'h0018));
    checkOutput("ramp_word23", 1024'(frame_o[23*32 +: 32]), 1024'(23));

    // Hold FULL with words offered; nothing may move until the handshake.
    repeat (10) applyStimulus(1'b1, $urandom, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("take_idx", 1024'(word_idx_o), 1024'(0));
    checkOutput("take_ready", 1024'(word_ready_o), 1024'(1));

    // All-ones last word: only the low 16 bits land.
    for (int j = 0; j < N_WORDS - 1; j++) applyStimulus(1'b1, WIDTH'(j), 1'b0, 1'b0);
    prevCount = refCount;
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    topBits = frame_o[783:768];
    checkOutput("ones_top", 1024'(topBits), 1024'(16'hFFFF));
    checkOutput("ones_count_model", 1024'(refCount), 1024'(prevCount + 16));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Clear arriving together with a valid word drops that word.
    for (int j = 0; j < 7; j++) applyStimulus(1'b1, $urandom, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    checkOutput("clear_idx", 1024'(word_idx_o), 1024'(0));
    checkOutput("clear_frame", 1024'(frame_o), 1024'(0));
    checkOutput("clear_valid", 1024'(frame_valid_o), 1024'(0));

    // Asynchronous reset in the middle of a clock-high phase.
    for (int j = 0; j < 12; j++) applyStimulus(1'b1, $urandom, 1'b0, 1'b0);
    #3;
    rst_ni = 1'b0;
    word_valid_i = 1'b0;
    modelReset();
    #1;
    checkAll();
    checkOutput("async_idx", 1024'(word_idx_o), 1024'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int j = 0; j < N_WORDS; j++) applyStimulus(1'b1, $urandom, 1'b0, 1'b0);
    checkOutput("after_reset_valid", 1024'(frame_valid_o), 1024'(1));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Random gaps, random consumer delay, occasional clear.
    framesDone = 0;
    cycles = 0;
    while (framesDone < 100 && cycles < 20000) begin
      v  = ($urandom_range(0, 3) != 0);
      c  = ($urandom_range(0, 199) == 0);
      fr = ($urandom_range(0, 2) == 0);
      if (refFull && fr && !c) framesDone++;
      applyStimulus(v, $urandom, fr, c);
      cycles++;
    end
    if (framesDone < 100) checkOutput("random_timeout", 1024'(framesDone), 1024'(100));

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
